// File: rtl/uart_pkg.sv
// uart_pkg: frame constants, TX FSM encoding and bit-period helper; UART_TX_PARITY_EN adds the PARITY state
package uart_pkg;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif

    function automatic int calc_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// uart_tx_fifo_mem: byte FIFO with wrapping pointers, occupancy count and registered full/empty flags
module uart_tx_fifo_mem #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_acc;
    logic          rd_acc;
    logic [AW:0]   count_n;

    assign wr_acc  = wr_en && !full;
    assign rd_acc  = rd_en && !empty;
    assign count_n = count + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
    assign rd_data = mem[rd_ptr];

    // storage is not reset: pointers alone define what is queued
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= wr_data;
    end

    // pointers wrap naturally because DEPTH is a power of two; flags registered from next count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_acc);
            rd_ptr <= rd_ptr + AW'(rd_acc);
            count  <= count_n;
            full   <= count_n == (AW+1)'(DEPTH);
            empty  <= count_n == '0;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN is defined)
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 40000000,
    parameter int BAUD     = 9600,
    parameter int DEPTH    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             tx_data,
    input  logic                   tx_wr,
    output logic                   tx_full,
    output logic                   tx_empty,
    output logic [$clog2(DEPTH):0] tx_count,
    output logic                   tx_busy,
    output logic                   txd
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam int CW  = $clog2(DIV + 1);

    tx_state_t     state;
    tx_state_t     state_n;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    fifo_data;
    logic          tick;
    logic          last_bit;
    logic          pop;
`ifdef UART_TX_PARITY_EN
    logic          par;
`endif

    uart_tx_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tx_wr),
        .wr_data (tx_data),
        .rd_en   (pop),
        .rd_data (fifo_data),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count)
    );

    assign tick     = baud_cnt == CW'(DIV - 1);
    assign last_bit = bit_idx == 3'(DATA_BITS - 1);

    // next state and pop decision; STOP chains straight into START when more data is queued
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                pop     = !tx_empty;
                state_n = tx_empty ? IDLE : START;
            end
            START:  state_n = tick ? DATA : START;
`ifdef UART_TX_PARITY_EN
            DATA:   state_n = (tick && last_bit) ? PARITY : DATA;
            PARITY: state_n = tick ? STOP : PARITY;
`else
            DATA:   state_n = (tick && last_bit) ? STOP : DATA;
`endif
            STOP: begin
                pop     = tick && !tx_empty;
                state_n = !tick ? STOP : tx_empty ? IDLE : START;
            end
            default: state_n = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // baud counter, bit index and shifter; parity captured at load since the shifter consumes the byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            baud_cnt <= (state == IDLE || tick) ? '0 : baud_cnt + 1'b1;
            if (pop) begin
                shreg   <= fifo_data;
                bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                par     <= ^fifo_data;
`endif
            end else if (state == DATA && tick) begin
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    // registered line and busy outputs, one cycle behind the state so every bit lasts exactly DIV cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txd     <= STOP_BIT;
            tx_busy <= 1'b0;
        end else begin
            tx_busy <= state != IDLE;
`ifdef UART_TX_PARITY_EN
            txd     <= state == START ? START_BIT : state == DATA ? shreg[0] : state == PARITY ? par : STOP_BIT;
`else
            txd     <= state == START ? START_BIT : state == DATA ? shreg[0] : STOP_BIT;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: vector table, corner sequences and random traffic against a queue-based line model
module tb_uart_tx_fifo;

    localparam int CLK_FREQ = 16;
    localparam int BAUD     = 1;
    localparam int DEPTH    = 8;
    localparam int DIV      = 16;
    localparam int CNTW     = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      tx_data = 8'h00;
    logic            tx_wr = 1'b0;
    logic            tx_full;
    logic            tx_empty;
    logic [CNTW-1:0] tx_count;
    logic            tx_busy;
    logic            txd;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_wr    (tx_wr),
        .tx_full  (tx_full),
        .tx_empty (tx_empty),
        .tx_count (tx_count),
        .tx_busy  (tx_busy),
        .txd      (txd)
    );

    typedef struct {
        logic [7:0]  data;
        logic [10:0] line;
    } vec_t;

    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    logic [7:0] q[$];
    logic       active = 1'b0;
    int         p = 0;
    logic [7:0] cur = 8'h00;
    vec_t       vt[5];

    function automatic logic frame_bit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
        if (i == FB - 1) return 1'b1;
        return ^d;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic wr, input logic [7:0] d);
        logic exp_txd;
        logic exp_busy;
        logic pop;
        logic accept;
        tx_wr   = wr;
        tx_data = d;
        @(posedge clk);
        cyc++;
        exp_txd  = 1'b1;
        exp_busy = 1'b0;
        if (rst) begin
            q.delete();
            active = 1'b0;
        end else begin
            if (active && cyc > p) begin
                exp_txd  = frame_bit(cur, (cyc - p - 1) / DIV);
                exp_busy = 1'b1;
            end
            pop    = q.size() > 0 && (!active || cyc == p + FB * DIV);
            accept = wr && q.size() < DEPTH;
            if (active && cyc == p + FB * DIV && !pop) active = 1'b0;
            if (pop) begin
                cur    = q.pop_front();
                p      = cyc;
                active = 1'b1;
            end
            if (accept) q.push_back(d);
        end
        #1;
        check("txd", txd, exp_txd);
        check("tx_busy", tx_busy, exp_busy);
        check("tx_count", tx_count, q.size());
        check("tx_empty", tx_empty, q.size() == 0);
        check("tx_full", tx_full, q.size() == DEPTH);
        tx_wr = 1'b0;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        rst = 1'b0;
    endtask

    task automatic async_reset();
        #1 rst = 1'b1;
        #1;
        check("arst_txd", txd, 1'b1);
        check("arst_busy", tx_busy, 1'b0);
        check("arst_count", tx_count, 0);
        check("arst_empty", tx_empty, 1'b1);
        check("arst_full", tx_full, 1'b0);
        q.delete();
        active = 1'b0;
    endtask

    initial begin
        int e0;
        int gaps;
        int first_empty;
        int max_cnt;
`ifdef UART_TX_PARITY_EN
        vt[0] = '{8'h55, {1'b1, 1'b0, 8'h55, 1'b0}};
        vt[1] = '{8'h07, {1'b1, 1'b1, 8'h07, 1'b0}};
        vt[2] = '{8'h00, {1'b1, 1'b0, 8'h00, 1'b0}};
        vt[3] = '{8'hFF, {1'b1, 1'b0, 8'hFF, 1'b0}};
        vt[4] = '{8'h80, {1'b1, 1'b1, 8'h80, 1'b0}};
`else
        vt[0] = '{8'h55, {2'b11, 8'h55, 1'b0}};
        vt[1] = '{8'h07, {2'b11, 8'h07, 1'b0}};
        vt[2] = '{8'h00, {2'b11, 8'h00, 1'b0}};
        vt[3] = '{8'hFF, {2'b11, 8'hFF, 1'b0}};
        vt[4] = '{8'h80, {2'b11, 8'h80, 1'b0}};
`endif

        for (int n = 0; n < 5; n++) begin
            do_reset();
            step(1'b1, vt[n].data);
            e0 = cyc;
            check("first_write_count", tx_count, 1);
            step(1'b0, 8'h00);
            check("start_not_yet", txd, 1'b1);
            step(1'b0, 8'h00);
            check("start_low_at_2", txd, 1'b0);
            for (int i = 0; i < FB; i++) begin
                run_to(e0 + 2 + i * DIV + DIV / 2);
                check("frame_bit", txd, vt[n].line[i]);
            end
            run_to(e0 + 1 + FB * DIV);
            check("busy_last_cycle", tx_busy, 1'b1);
            step(1'b0, 8'h00);
            check("busy_dropped", tx_busy, 1'b0);
        end

        do_reset();
        step(1'b1, 8'h01);
        e0 = cyc;
        step(1'b1, 8'h02);
        step(1'b1, 8'h03);
        gaps = 0;
        first_empty = 0;
        while (cyc < e0 + 1 + 3 * FB * DIV) begin
            step(1'b0, 8'h00);
            if (!tx_busy) gaps++;
            if (tx_empty && first_empty == 0) first_empty = cyc;
        end
        check("b2b_idle_gaps", gaps, 0);
        check("b2b_empty_cycle", first_empty, e0 + 1 + 2 * FB * DIV);
        run_to(cyc + 4);

        do_reset();
        step(1'b1, 8'hA0);
        run_to(cyc + 3);
        max_cnt = 0;
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, 8'hA0 + 8'(i));
            if (int'(tx_count) > max_cnt) max_cnt = int'(tx_count);
            if (i == 8) check("full_after_8", tx_full, 1'b1);
        end
        check("count_after_9", tx_count, 8);
        check("max_count", max_cnt, 8);
        run_to(p + FB * DIV - 1);
        step(1'b1, 8'hEE);
        check("full_pop_drop_count", tx_count, 7);
        run_to(cyc + 9 * FB * DIV + 4);
        check("drained_empty", tx_empty, 1'b1);

        do_reset();
        step(1'b1, 8'h11);
        e0 = cyc;
        step(1'b1, 8'h22);
        run_to(e0 + 1 + 40);
        async_reset();
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        rst = 1'b0;
        step(1'b1, 8'h3C);
        check("post_reset_accept", tx_count, 1);
        run_to(cyc + FB * DIV + 4);

        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 29) == 0, 8'($urandom));
        run_to(cyc + (DEPTH + 1) * FB * DIV + 4);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
